// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the context-switching register file.
package regfile_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE,
    DONE
  } ctx_state_t;

endpackage

// File: rtl/regfile_bank.sv
// DEPTH x DW storage: one synchronous write port, NR combinational reads.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NR = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [DW-1:0]          wdata,
  input  logic [NR-1:0][AW-1:0]  raddr,
  output logic [NR-1:0][DW-1:0]  rdata
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int r = 0; r < NR; r++)
      rdata[r] = mem[raddr[r]];
  end

endmodule

// File: rtl/regfile_ctx.sv
// Two-port register file with a shadow bank for whole-context save/restore.
module regfile_ctx
  import regfile_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          mov_instr,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] dat_in,
  output logic [DW-1:0] dat_a_out,
  output logic [DW-1:0] dat_b_out,
  input  logic          save_req,
  input  logic          restore_req,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST = '1;

  ctx_state_t state, state_nxt;
  logic [AW-1:0] idx;
  logic [AW-1:0] wtgt;
  logic          wr_ok;

  logic          core_we;
  logic [AW-1:0] core_wa;
  logic [DW-1:0] core_wd;
  logic [2:0][DW-1:0] core_rd;
  logic [0:0][DW-1:0] shd_rd;

  assign busy  = (state == SAVE) || (state == RESTORE);
  assign done  = (state == DONE);
  assign wtgt  = mov_instr ? addr_a : '0;
  assign wr_ok = wr_en && !busy;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (save_req)         state_nxt = SAVE;
        else if (restore_req) state_nxt = RESTORE;
      end
      SAVE, RESTORE: begin
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // idx sits at zero outside a copy, so entering SAVE/RESTORE starts at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= busy ? idx + 1'b1 : '0;
    end
  end

  always_comb begin
    core_we = 1'b0;
    core_wa = wtgt;
    core_wd = dat_in;
    if (state == RESTORE) begin
      core_we = 1'b1;
      core_wa = idx;
      core_wd = shd_rd[0];
    end else if (wr_ok) begin
      core_we = 1'b1;
    end
  end

  regfile_bank #(.DW(DW), .AW(AW), .NR(3)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (core_we),
    .waddr (core_wa),
    .wdata (core_wd),
    .raddr ({idx, addr_b, addr_a}),
    .rdata (core_rd)
  );

  regfile_bank #(.DW(DW), .AW(AW), .NR(1)) u_shadow (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (state == SAVE),
    .waddr (idx),
    .wdata (core_rd[2]),
    .raddr (idx),
    .rdata (shd_rd)
  );

  always_comb begin
    dat_a_out = core_rd[0];
    dat_b_out = core_rd[1];
    if (BYPASS != 0 && wr_ok) begin
      if (addr_a == wtgt) dat_a_out = dat_in;
      if (addr_b == wtgt) dat_b_out = dat_in;
    end
  end

endmodule

// File: tb/tb_regfile_ctx.sv
// Directed self-checking bench for regfile_ctx.
module tb_regfile_ctx;
  import regfile_pkg::*;

  logic       clk = 0;
  logic       rst_n;
  logic       wr_en, mov_instr, save_req, restore_req;
  logic [2:0] addr_a, addr_b;
  logic [7:0] dat_in;
  logic [7:0] dat_a_out, dat_b_out;
  logic       busy, done;

  int checks = 0;
  int failures = 0;
  int n;

  regfile_ctx #(.DW(8), .AW(3), .BYPASS(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .mov_instr   (mov_instr),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .dat_in      (dat_in),
    .dat_a_out   (dat_a_out),
    .dat_b_out   (dat_b_out),
    .save_req    (save_req),
    .restore_req (restore_req),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic mov, input logic [2:0] a,
                    input logic [7:0] d);
    wr_en = 1; mov_instr = mov; addr_a = a; dat_in = d;
    tick();
    wr_en = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a,
                        input logic [7:0] exp);
    wr_en = 0; addr_a = a; addr_b = a;
    #1;
    check({tag, "_a"}, dat_a_out, exp);
    check({tag, "_b"}, dat_b_out, exp);
  endtask

  // count busy cycles, bounded
  task automatic run_copy(input logic drop_wr);
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    if (drop_wr) wr_en = 0;
  endtask

  initial begin
    rst_n = 0; wr_en = 0; mov_instr = 0; save_req = 0; restore_req = 0;
    addr_a = 0; addr_b = 0; dat_in = 0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rd_chk("rst_r5", 3'd5, 8'h00);
    #3 rst_n = 1;
    tick();

    // mov write to r3, accumulator write lands in r0 not r5
    wr(1, 3'd3, 8'h5A);
    wr(0, 3'd5, 8'h11);
    for (int i = 0; i < 8; i++)
      rd_chk($sformatf("basic_r%0d", i), 3'(i),
             i == 3 ? 8'h5A : (i == 0 ? 8'h11 : 8'h00));

    // same-cycle forwarding
    wr_en = 1; mov_instr = 1; addr_a = 2; addr_b = 2; dat_in = 8'hC3;
    #1;
    check("byp_a", dat_a_out, 8'hC3);
    check("byp_b", dat_b_out, 8'hC3);
    tick();
    wr_en = 0;
    rd_chk("byp_commit", 3'd2, 8'hC3);
    wr_en = 1; mov_instr = 0; addr_a = 6; addr_b = 0; dat_in = 8'h77;
    #1;
    check("byp_acc_b", dat_b_out, 8'h77);
    check("byp_acc_a", dat_a_out, 8'h00);
    wr_en = 0;
    #1;
    check("byp_off_b", dat_b_out, 8'h11);

    // fill, with r7 written on the edge that accepts save_req
    for (int i = 0; i < 7; i++) wr(1, 3'(i), 8'(8'h10 + i));
    save_req = 1;
    wr(1, 3'd7, 8'h17);
    save_req = 0;
    check("save_busy0", busy, 1);
    run_copy(0);
    check("save_cycles", n, 8);
    check("save_done", done, 1);
    tick();
    check("save_done_clr", done, 0);
    check("save_idle", busy, 0);
    for (int i = 0; i < 8; i++)
      check($sformatf("shadow_%0d", i), dut.u_shadow.mem[i], 8'h10 + i);

    // overwrite, restore while hammering writes that must be dropped
    for (int i = 0; i < 8; i++) wr(1, 3'(i), 8'hFF);
    restore_req = 1;
    tick();
    restore_req = 0;
    wr_en = 1; mov_instr = 1; addr_a = 4; addr_b = 0; dat_in = 8'h99;
    #1;
    check("rest_busy", busy, 1);
    check("rest_partial_r4", dat_a_out, 8'hFF);
    run_copy(1);
    check("rest_cycles", n, 8);
    check("rest_done", done, 1);
    tick();
    for (int i = 0; i < 8; i++)
      rd_chk($sformatf("rest_r%0d", i), 3'(i), 8'h10 + i);

    // simultaneous requests pick save; restore during save is ignored
    wr(1, 3'd1, 8'h41);
    save_req = 1; restore_req = 1;
    tick();
    save_req = 0; restore_req = 0;
    tick();
    restore_req = 1;
    tick();
    restore_req = 0;
    n = 2;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    check("both_cycles", n, 8);
    check("both_done", done, 1);
    tick();
    tick();
    check("both_no_queue", busy, 0);
    check("both_shadow1", dut.u_shadow.mem[1], 8'h41);
    rd_chk("both_core1", 3'd1, 8'h41);

    // reset mid-save at idx 4
    save_req = 1;
    tick();
    save_req = 0;
    repeat (4) tick();
    check("mid_idx", dut.idx, 4);
    rst_n = 0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_state", dut.state, IDLE);
    for (int i = 0; i < 8; i++) begin
      rd_chk($sformatf("mid_r%0d", i), 3'(i), 8'h00);
      check($sformatf("mid_sh%0d", i), dut.u_shadow.mem[i], 8'h00);
    end
    #2 rst_n = 1;
    wr(1, 3'd6, 8'h66);
    rd_chk("post_rst_wr", 3'd6, 8'h66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
